// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// ifu_fetch : instruction-fetch initiator for a single-cycle ROM, with a
//             one-entry {pc, inst} buffer toward decode, redirect and ebreak halt.
//             Optional perf counters under IFU_PERF_CNT_EN.
// Rev 1.0
// ============================================================================
module ifu_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign,
  output logic        halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [1:0]  ST_RUN    = 2'd0;
  localparam logic [1:0]  ST_DRAIN  = 2'd1;
  localparam logic [1:0]  ST_HALTED = 2'd2;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [31:2] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        misalign_q, misalign_d;

  logic redirect_take;
  logic fetch_en;
  logic capture;
  logic accept;

  // Redirect outranks everything except a completed halt.
  assign redirect_take = redirect_valid && (state_q != ST_HALTED);
  assign fetch_en      = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign capture       = fetch_en && !redirect_take;
  assign accept        = out_valid_q && out_ready;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (capture && (imem_data == EBREAK_INST)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (redirect_take) begin
          state_d = ST_RUN;
        end else if (accept) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    halted = (state_q == ST_HALTED);
  end

  always_comb begin
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    misalign_d  = misalign_q;
    if (redirect_take) begin
      // Flush the buffer even when decode is accepting it this cycle.
      pc_d        = redirect_pc[31:2];
      out_valid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (capture) begin
      out_pc_d    = {pc_q, 2'b00};
      out_inst_d  = imem_data;
      out_valid_d = 1'b1;
      pc_d        = pc_q + 30'd1;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC[31:2];
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'h0000_0000;
      out_inst_q  <= NOP_INST;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      misalign_q  <= misalign_d;
    end
  end

  assign imem_addr = {pc_q, 2'b00};
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;
  assign misalign  = misalign_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q != ST_HALTED) begin
      if (capture) begin
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (out_valid_q && !out_ready) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// tb_ifu_fetch : directed scenarios plus randomized traffic checked every cycle
//                against a transaction-level fetch model.
// Rev 1.0
// ============================================================================
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EBRK     = 32'h0010_0073;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;
  logic        halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [31:0] prog [0:15];
  bit          rom_nop = 1'b0;

  always #5 clk = ~clk;

  assign imem_data = (rom_nop || (imem_addr[31:6] != 26'd0)) ? NOP : prog[imem_addr[5:2]];

  ifu_fetch #(.RESET_PC(RESET_PC), .EBREAK_INST(EBRK)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .misalign(misalign), .halted(halted)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (rom_nop || (a[31:6] != 26'd0)) return NOP;
    return prog[a[5:2]];
  endfunction

  // Reference model: one fetch slot; drain after ebreak is taken; halt when it leaves.
  logic [31:0] m_pc, m_opc, m_inst, m_fcnt, m_scnt;
  logic        m_valid, m_mis, m_halt, m_drain;

  always @(posedge clk or posedge rst) begin : model
    logic [31:0] n_pc, n_opc, n_inst, n_fcnt, n_scnt;
    logic        n_valid, n_mis, n_halt, n_drain;
    if (rst) begin
      m_pc <= RESET_PC; m_opc <= 32'd0; m_inst <= NOP; m_valid <= 1'b0;
      m_mis <= 1'b0; m_halt <= 1'b0; m_drain <= 1'b0; m_fcnt <= 32'd0; m_scnt <= 32'd0;
    end else if (!m_halt) begin
      n_pc = m_pc; n_opc = m_opc; n_inst = m_inst; n_valid = m_valid;
      n_mis = m_mis; n_halt = m_halt; n_drain = m_drain; n_fcnt = m_fcnt; n_scnt = m_scnt;
      if (m_valid && !out_ready) n_scnt = m_scnt + 1;
      if (redirect_valid) begin
        n_pc = redirect_pc & ~32'd3;
        n_valid = 1'b0;
        n_drain = 1'b0;
        if (redirect_pc % 4 != 0) n_mis = 1'b1;
      end else if (!m_drain && (!m_valid || out_ready)) begin
        n_opc = m_pc;
        n_inst = rom_word(m_pc);
        n_valid = 1'b1;
        n_pc = m_pc + 4;
        n_fcnt = m_fcnt + 1;
        if (n_inst == EBRK) n_drain = 1'b1;
      end else if (m_valid && out_ready) begin
        n_valid = 1'b0;
        if (m_drain) n_halt = 1'b1;
      end
      m_pc <= n_pc; m_opc <= n_opc; m_inst <= n_inst; m_valid <= n_valid;
      m_mis <= n_mis; m_halt <= n_halt; m_drain <= n_drain; m_fcnt <= n_fcnt; m_scnt <= n_scnt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_out_valid", out_valid, m_valid);
      chk("m_out_pc", out_pc, m_opc);
      chk("m_out_inst", out_inst, m_inst);
      chk("m_misalign", misalign, m_mis);
      chk("m_halted", halted, m_halt);
`ifdef IFU_PERF_CNT_EN
      chk("m_fetch_cnt", fetch_cnt, m_fcnt);
      chk("m_stall_cnt", stall_cnt, m_scnt);
`endif
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pc(input logic [31:0] t);
    int k = 0;
    while (!(out_valid && out_pc == t) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("wait_pc_reached", out_pc, t);
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = 32'hAAAAA2B7; prog[1] = 32'h00100093; prog[2] = 32'h06400313;
    prog[3] = 32'h006282B3; prog[4] = 32'h00000013; prog[5] = 32'h00308193;
    prog[6] = 32'h00418213; prog[7] = 32'h00200113; prog[8] = EBRK;
    for (int i = 9; i < 16; i++) prog[i] = NOP;
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 32'd0);
    chk("reset_out_inst", out_inst, NOP);
    chk("reset_imem_addr", imem_addr, RESET_PC);
    chk_en = 1'b1;

    // Streaming run to ebreak
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t1_out_pc", out_pc, 32'(i * 4));
      chk("t1_out_valid", out_valid, 32'd1);
      if (i == 0) chk("t1_first_inst", out_inst, 32'hAAAAA2B7);
    end
    @(negedge clk);
    chk("t1_halted", halted, 32'd1);
    chk("t1_imem_addr", imem_addr, 32'h24);
    chk("t1_valid_after_halt", out_valid, 32'd0);

    // Back-pressure
    do_reset();
    wait_pc(32'h08);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_pc", out_pc, 32'h08);
      chk("t2_hold_inst", out_inst, 32'h06400313);
      chk("t2_hold_addr", imem_addr, 32'h0C);
    end
`ifdef IFU_PERF_CNT_EN
    chk("t2_stall_cnt", stall_cnt, 32'd3);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_resume_pc", out_pc, 32'h0C);

    // Redirect flush, then misaligned redirect
    do_reset();
    wait_pc(32'h18);
    redirect(32'h1C);
    chk("t3_flushed", out_valid, 32'd0);
    @(negedge clk);
    chk("t3_target_pc", out_pc, 32'h1C);
    chk("t3_target_inst", out_inst, 32'h00200113);
    redirect(32'h1E);
    chk("t4_addr", imem_addr, 32'h1C);
    chk("t4_misalign", misalign, 32'd1);
    redirect(32'h04);
    @(negedge clk);
    chk("t4_misalign_sticky", misalign, 32'd1);

    // Redirect during drain, then redirect while halted
    do_reset();
    wait_pc(32'h20);
    redirect(32'h00);
    chk("t5_flushed", out_valid, 32'd0);
    chk("t5_not_halted", halted, 32'd0);
    chk("t5_restart_addr", imem_addr, 32'h00);
    @(negedge clk);
    chk("t5_restart_pc", out_pc, 32'h00);
    for (int k = 0; k < 40 && !halted; k++) @(negedge clk);
    chk("t5_halted", halted, 32'd1);
    redirect(32'h40);
    chk("t5_ignored_addr", imem_addr, 32'h24);
    chk("t5_still_halted", halted, 32'd1);

    // Address wrap and asynchronous reset
    rom_nop = 1'b1;
    do_reset();
    redirect(32'hFFFF_FFFC);
    chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("t6_wrap_addr", imem_addr, 32'h0000_0000);
    chk("t6_wrap_pc", out_pc, 32'hFFFF_FFFC);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 32'd0);
    chk("t6_async_addr", imem_addr, RESET_PC);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    rom_nop = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc = $urandom();
      else redirect_pc = $urandom_range(0, 63);
      if ((halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
